// File: rtl/a5gx_starter_fpga_bup_qsys_cpu_div_cell.sv
// Iterative radix-2 restoring divider for the CPU execute path (div/divu/rem).
// One quotient bit per clock; sign handled by abs on entry and negate on exit.
module a5gx_starter_fpga_bup_qsys_cpu_div_cell #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             E_div_start,
  input  logic             E_div_abort,
  input  logic             E_ctrl_div_signed,
  input  logic [WIDTH-1:0] E_src1_div_cell,
  input  logic [WIDTH-1:0] E_src2_div_cell,
  output logic             A_div_busy,
  output logic             A_div_done,
  output logic [WIDTH-1:0] A_div_quot,
  output logic [WIDTH-1:0] A_div_rem,
  output logic             A_div_by_zero
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd_q;     // dividend bits shift out the top, quotient bits shift in the bottom
  logic [WIDTH-1:0] dvsr;
  logic [WIDTH-1:0] prem;
  logic [WIDTH-1:0] src1_org;
  logic             neg_q, neg_r, dz;

  logic [WIDTH-1:0] abs1, abs2;
  logic [WIDTH:0]   shifted, diff;

  // abs(-2^(WIDTH-1)) wraps to itself, which is the correct unsigned magnitude
  assign abs1 = (E_ctrl_div_signed && E_src1_div_cell[WIDTH-1]) ? -E_src1_div_cell : E_src1_div_cell;
  assign abs2 = (E_ctrl_div_signed && E_src2_div_cell[WIDTH-1]) ? -E_src2_div_cell : E_src2_div_cell;

  // partial remainder < divisor, so diff[WIDTH] is a clean borrow flag
  assign shifted = {prem, dvd_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvsr};

  assign A_div_busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      dvd_q         <= '0;
      dvsr          <= '0;
      prem          <= '0;
      src1_org      <= '0;
      neg_q         <= 1'b0;
      neg_r         <= 1'b0;
      dz            <= 1'b0;
      A_div_done    <= 1'b0;
      A_div_quot    <= '0;
      A_div_rem     <= '0;
      A_div_by_zero <= 1'b0;
    end else begin
      A_div_done <= 1'b0;
      case (state)
        IDLE: begin
          if (E_div_start && !E_div_abort) begin
            state    <= CALC;
            cnt      <= '0;
            dvd_q    <= abs1;
            dvsr     <= abs2;
            prem     <= '0;
            src1_org <= E_src1_div_cell;
            neg_q    <= E_ctrl_div_signed & (E_src1_div_cell[WIDTH-1] ^ E_src2_div_cell[WIDTH-1]);
            neg_r    <= E_ctrl_div_signed & E_src1_div_cell[WIDTH-1];
            dz       <= (E_src2_div_cell == '0);
          end
        end
        CALC: begin
          if (E_div_abort) begin
            state <= IDLE;
          end else begin
            dvd_q <= {dvd_q[WIDTH-2:0], ~diff[WIDTH]};
            prem  <= diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
            if (cnt == CW'(WIDTH-1)) begin
              cnt   <= '0;
              state <= FIX;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        FIX: begin
          state <= IDLE;
          if (!E_div_abort) begin
            A_div_done    <= 1'b1;
            A_div_quot    <= dz ? '1 : (neg_q ? -dvd_q : dvd_q);
            A_div_rem     <= dz ? src1_org : (neg_r ? -prem : prem);
            A_div_by_zero <= dz;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_a5gx_starter_fpga_bup_qsys_cpu_div_cell.sv
// Self-checking bench: directed corner cases plus random regression against an arithmetic model.
module tb_a5gx_starter_fpga_bup_qsys_cpu_div_cell;
  localparam int W = 32;
  localparam int LAT = 34;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0, abort = 1'b0, sgn = 1'b0;
  logic [W-1:0] src1 = '0, src2 = '0;
  logic         busy, done, by_zero;
  logic [W-1:0] quot, rem;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  a5gx_starter_fpga_bup_qsys_cpu_div_cell #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .E_div_start(start), .E_div_abort(abort), .E_ctrl_div_signed(sgn),
    .E_src1_div_cell(src1), .E_src2_div_cell(src2),
    .A_div_busy(busy), .A_div_done(done),
    .A_div_quot(quot), .A_div_rem(rem), .A_div_by_zero(by_zero)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Truncating division: quotient rounds toward zero, remainder follows the dividend
  task automatic model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
    longint sa, sb;
    z = (b == 0);
    if (z) begin
      q = '1;
      r = a;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = W'(sa / sb);
      r = W'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endtask

  // Issue one op and wait for done; returns #1 after the done edge (still inside the done cycle)
  task automatic run_op(input string tag, input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] eq, er;
    logic ez;
    int lat;
    bit busy_ok;
    model(s, a, b, eq, er, ez);
    @(negedge clk);
    sgn = s; src1 = a; src2 = b; start = 1'b1;
    lat = 0; busy_ok = 1'b1;
    for (int k = 1; k <= LAT + 6; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        start = 1'b0;
        src1 = $urandom; src2 = $urandom; sgn = ~s;  // operands must be ignored after accept
      end
      if (done) begin
        lat = k;
        break;
      end
      if (!busy) busy_ok = 1'b0;
    end
    chk({tag, ".lat"}, lat, LAT);
    chk({tag, ".busy_during"}, busy_ok, 1);
    chk({tag, ".busy_at_done"}, busy, 0);
    chk({tag, ".quot"}, quot, eq);
    chk({tag, ".rem"}, rem, er);
    chk({tag, ".dz"}, by_zero, ez);
  endtask

  // Count done pulses over n cycles
  task automatic count_done(input int n, output int cnt);
    cnt = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      if (done) cnt++;
    end
  endtask

  initial begin
    logic [W-1:0] pq, pr;
    logic pz;
    int nd;
    logic [W-1:0] ra, rb;
    logic rs;

    #12;
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.quot", quot, 0);
    chk("rst.rem", rem, 0);
    chk("rst.dz", by_zero, 0);
    @(negedge clk); reset = 1'b0;

    run_op("u100_7", 1'b0, 32'd100, 32'd7);
    run_op("s-7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
    run_op("s7_-2", 1'b1, 32'd7, 32'hFFFF_FFFE);
    run_op("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("u_ovf", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("u_dz", 1'b0, 32'h1234_5678, 32'd0);
    run_op("s_dz", 1'b1, 32'h1234_5678, 32'd0);
    run_op("s_dzneg", 1'b1, 32'h8765_4321, 32'd0);

    // Abort in CALC: busy drops next edge, no done, outputs hold
    pq = quot; pr = rem; pz = by_zero;
    @(negedge clk); sgn = 1'b0; src1 = 32'd1000; src2 = 32'd3; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (10) @(negedge clk);
    chk("abort.busy_before", busy, 1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort.busy_after", busy, 0);
    count_done(LAT + 4, nd);
    chk("abort.no_done", nd, 0);
    chk("abort.quot_hold", quot, pq);
    chk("abort.rem_hold", rem, pr);
    chk("abort.dz_hold", by_zero, pz);

    // Abort with start in IDLE: nothing accepted
    @(negedge clk); start = 1'b1; abort = 1'b1; src1 = 32'd9; src2 = 32'd2;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    chk("idle_abort.busy", busy, 0);

    // Abort coinciding with the FIX edge: no done, no update
    @(negedge clk); sgn = 1'b0; src1 = 32'd77; src2 = 32'd5; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (LAT - 2) @(posedge clk);
    #1; abort = 1'b1;
    chk("fix_abort.busy_before", busy, 1);
    @(posedge clk); #1; abort = 1'b0;
    chk("fix_abort.done", done, 0);
    chk("fix_abort.busy", busy, 0);
    chk("fix_abort.quot_hold", quot, pq);
    count_done(LAT + 2, nd);
    chk("fix_abort.no_done", nd, 0);

    // Back-to-back: the second run_op raises start inside the first op's done cycle
    run_op("b2b_a", 1'b0, 32'd1000, 32'd33);
    run_op("b2b_b", 1'b1, 32'hFFFF_FC18, 32'd7);

    // Start while busy is ignored: exactly one done, original operands' result
    @(negedge clk); sgn = 1'b0; src1 = 32'd500; src2 = 32'd9; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    src1 = 32'd1; src2 = 32'd1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    count_done(2 * LAT + 4, nd);
    chk("busy_start.one_done", nd, 1);
    chk("busy_start.quot", quot, 32'd55);
    chk("busy_start.rem", rem, 32'd5);

    // Reset mid-calc: outputs clear asynchronously, no done afterwards
    @(negedge clk); sgn = 1'b0; src1 = 32'd200; src2 = 32'd3; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (20) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst.busy", busy, 0);
    chk("midrst.quot", quot, 0);
    chk("midrst.rem", rem, 0);
    chk("midrst.dz", by_zero, 0);
    @(negedge clk); reset = 1'b0;
    count_done(LAT + 4, nd);
    chk("midrst.no_done", nd, 0);

    // Random regression: mix wide, narrow and zero divisors
    for (int i = 0; i < 40; i++) begin
      rs = $urandom_range(0, 1);
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = 32'd0;
        1: rb = $urandom_range(1, 20);
        2: rb = -$urandom_range(1, 20);
        default: rb = $urandom;
      endcase
      run_op($sformatf("rnd%0d", i), rs, ra, rb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout got=1 exp=0");
    $fatal(1, "timeout");
  end
endmodule
